// File: rtl/nes_video_pkg.sv
// Shared timing constants and types for the NES-on-MTL video path.
package nes_video_pkg;

   localparam int HSYNC_W   = 30;
   localparam int VSYNC_W   = 13;
   localparam int H_VIS0    = 50;
   localparam int V_VIS0    = 23;
   localparam int IMG_X0    = 194;
   localparam int IMG_W     = 512;
   localparam int NES_LINES = 240;
   localparam int H_VIS_W   = 800;
   localparam int V_VIS_H   = 480;

   // Each NES line is requested one NES line (two display lines) before it is shown.
   localparam int FETCH_LEAD    = 2;
   localparam int FETCH_FIRST   = V_VIS0 - FETCH_LEAD;
   localparam int FETCH_LAST    = FETCH_FIRST + 2 * (NES_LINES - 1);
   localparam int DEADLINE_LAST = FETCH_LAST + FETCH_LEAD;

   typedef enum logic [1:0] {IDLE, REQ, WAIT_DEADLINE} fetch_state_t;

   typedef struct packed {
      logic hsd;
      logic vsd;
      logic de;
      logic img;
   } vid_ctl_t;

   localparam vid_ctl_t VID_CTL_RST = '{hsd: 1'b1, vsd: 1'b1, de: 1'b0, img: 1'b0};

endpackage

// File: rtl/mtl_fetch_ctl.sv
// Line-fetch handshake: one outstanding request to the renderer, retired by ack or by its deadline.
module mtl_fetch_ctl
   import nes_video_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_start,
   input  logic       i_deadline,
   input  logic [7:0] i_line,
   input  logic       i_fetch_ack,
   output logic       o_fetch_req,
   output logic [7:0] o_fetch_line,
   output logic       o_underrun
);

   fetch_state_t state_q, state_d;
   logic [7:0]   line_q, line_d;
   logic         underrun_q, underrun_d;

   // NOTE: reset is synchronous, so it sits inside the clocked block and acts only on an edge.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= IDLE;
         line_q     <= '0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         line_q     <= line_d;
         underrun_q <= underrun_d;
      end
   end

   // NOTE: every variable gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      line_d     = line_q;
      underrun_d = underrun_q;
      case (state_q)
         REQ: begin
            if (i_fetch_ack) begin
               state_d = i_deadline ? IDLE : WAIT_DEADLINE;
            end else if (i_deadline) begin
               underrun_d = 1'b1;
               state_d    = IDLE;
            end
         end
         WAIT_DEADLINE: if (i_deadline) state_d = IDLE;
         default: ;
      endcase
      // A newly due request takes over only after the old one has been retired above.
      if (i_start) begin
         state_d = REQ;
         line_d  = i_line;
      end
   end

   always_comb begin
      o_fetch_req  = (state_q == REQ);
      o_fetch_line = line_q;
      o_underrun   = underrun_q;
   end

endmodule

// File: rtl/mtl_scan_gen.sv
// MTL panel scan generator: raster counters, 2-stage video pipeline reading the NES line buffer.
module mtl_scan_gen
   import nes_video_pkg::*;
#(
   parameter int H_TOTAL = 1056,
   parameter int V_TOTAL = 525
) (
   input  logic        i_clk,
   input  logic        i_rst,
   output logic        o_hsd,
   output logic        o_vsd,
   output logic        o_de,
   output logic [7:0]  o_r,
   output logic [7:0]  o_g,
   output logic [7:0]  o_b,
   output logic        o_rd_bank,
   output logic [7:0]  o_rd_addr,
   input  logic [23:0] i_rd_rgb,
   output logic        o_fetch_req,
   output logic [7:0]  o_fetch_line,
   input  logic        i_fetch_ack,
   output logic        o_underrun,
   output logic        o_frame_start
);

   localparam int XW = $clog2(H_TOTAL);
   localparam int YW = $clog2(V_TOTAL);
   localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);

   logic [XW-1:0] xcnt, x_next;
   logic [YW-1:0] line_cnt, line_next;
   logic          frame_start_q;
   logic          h_vis, v_vis;
   vid_ctl_t      ctl0, ctl1, ctl2;
   logic [7:0]    nes_x0, rd_addr_q;
   logic          bank0, rd_bank_q;
   logic          fetch_start, fetch_deadline;
   logic [7:0]    fetch_line_next;

   always_comb begin
      x_next    = (xcnt == X_LAST) ? '0 : xcnt + 1'b1;
      line_next = line_cnt;
      if (xcnt == X_LAST) line_next = (line_cnt == Y_LAST) ? '0 : line_cnt + 1'b1;
   end

   // NOTE: state registers use <= so every flop samples the pre-edge value of its source.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         xcnt          <= '0;
         line_cnt      <= '0;
         frame_start_q <= 1'b0;
      end else begin
         xcnt          <= x_next;
         line_cnt      <= line_next;
         frame_start_q <= (x_next == '0) && (line_next == '0);
      end
   end

   always_comb begin
      h_vis     = (xcnt >= XW'(H_VIS0)) && (xcnt < XW'(H_VIS0 + H_VIS_W));
      v_vis     = (line_cnt >= YW'(V_VIS0)) && (line_cnt < YW'(V_VIS0 + V_VIS_H));
      ctl0.hsd  = (xcnt >= XW'(HSYNC_W));
      ctl0.vsd  = (line_cnt >= YW'(VSYNC_W));
      ctl0.de   = h_vis && v_vis;
      ctl0.img  = v_vis && (xcnt >= XW'(IMG_X0)) && (xcnt < XW'(IMG_X0 + IMG_W));
      nes_x0    = 8'((xcnt - XW'(IMG_X0)) >> 1);
      bank0     = 1'((line_cnt - YW'(V_VIS0)) >> 1);
   end

   // Fetch events are decoded from the next counter value so the FSM moves in step with xcnt=0.
   always_comb begin
      fetch_start     = (x_next == '0)
                        && (line_next >= YW'(FETCH_FIRST)) && (line_next <= YW'(FETCH_LAST))
                        && (1'(line_next - YW'(FETCH_FIRST)) == 1'b0);
      fetch_deadline  = (x_next == '0)
                        && (line_next >= YW'(V_VIS0)) && (line_next <= YW'(DEADLINE_LAST))
                        && (1'(line_next - YW'(V_VIS0)) == 1'b0);
      fetch_line_next = 8'((line_next - YW'(FETCH_FIRST)) >> 1);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ctl1      <= VID_CTL_RST;
         ctl2      <= VID_CTL_RST;
         rd_addr_q <= '0;
         rd_bank_q <= 1'b0;
      end else begin
         ctl1      <= ctl0;
         ctl2      <= ctl1;
         rd_addr_q <= nes_x0;
         rd_bank_q <= bank0;
      end
   end

   // The line buffer answers one cycle after the stage-1 address, lining up with stage 2.
   always_comb begin
      o_hsd             = ctl2.hsd;
      o_vsd             = ctl2.vsd;
      o_de              = ctl2.de;
      {o_r, o_g, o_b}   = ctl2.img ? i_rd_rgb : 24'h000000;
      o_rd_addr         = rd_addr_q;
      o_rd_bank         = rd_bank_q;
      o_frame_start     = frame_start_q;
   end

   mtl_fetch_ctl u_fetch_ctl (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_start      (fetch_start),
      .i_deadline   (fetch_deadline),
      .i_line       (fetch_line_next),
      .i_fetch_ack  (i_fetch_ack),
      .o_fetch_req  (o_fetch_req),
      .o_fetch_line (o_fetch_line),
      .o_underrun   (o_underrun)
   );

endmodule

// File: tb/tb_mtl_scan_gen.sv
// Directed bench for mtl_scan_gen: raster timing, pixel path, fetch handshake, underrun and reset.
module tb_mtl_scan_gen;

   localparam int H          = 1056;
   localparam int V          = 525;
   localparam int FRAME      = H * V;
   localparam int ACK_DELAY  = 100;
   localparam int SLOW_LINE  = 10;
   localparam int SLOW_DELAY = 2 * H;   // ack lands in the last cycle before the deadline
   localparam logic [46:0] RST_EXP = {2'b11, 45'd0};

   localparam int          PX_X   [8] = '{193, 194, 195, 196, 197, 300, 705, 706};
   localparam logic [23:0] PX_EXP [8] = '{24'h000000, 24'h000000, 24'h000000, 24'h010101,
                                          24'h010101, 24'h353535, 24'hffffff, 24'h000000};
   localparam int   DE_L   [7] = '{23, 23, 23, 23, 22, 502, 503};
   localparam int   DE_X   [7] = '{49, 50, 849, 850, 400, 400, 400};
   localparam logic DE_EXP [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fetch_ack = 1'b0;
   logic        extra_ack = 1'b0;
   logic [23:0] rd_rgb = '0;
   logic        o_hsd, o_vsd, o_de, o_rd_bank, o_fetch_req, o_underrun, o_frame_start;
   logic [7:0]  o_r, o_g, o_b, o_rd_addr, o_fetch_line;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int skip_line = -1;
   int ack_cnt = 0;
   int ack_prev = -1;

   always #5 clk = ~clk;

   mtl_scan_gen #(.H_TOTAL(H), .V_TOTAL(V)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .o_hsd         (o_hsd),
      .o_vsd         (o_vsd),
      .o_de          (o_de),
      .o_r           (o_r),
      .o_g           (o_g),
      .o_b           (o_b),
      .o_rd_bank     (o_rd_bank),
      .o_rd_addr     (o_rd_addr),
      .i_rd_rgb      (rd_rgb),
      .o_fetch_req   (o_fetch_req),
      .o_fetch_line  (o_fetch_line),
      .i_fetch_ack   (fetch_ack),
      .o_underrun    (o_underrun),
      .o_frame_start (o_frame_start)
   );

   // Line-buffer model: returns {addr, addr, addr} one cycle after the address.
   always @(posedge clk) rd_rgb <= {o_rd_addr, o_rd_addr, o_rd_addr};

   // Renderer model: acks each request ACK_DELAY cycles after it appears, never acks skip_line.
   always @(negedge clk) begin
      fetch_ack = extra_ack;
      if (rst || !o_fetch_req || int'(o_fetch_line) != ack_prev) ack_cnt = 0;
      ack_prev = o_fetch_req ? int'(o_fetch_line) : -1;
      if (!rst && o_fetch_req && int'(o_fetch_line) != skip_line) begin
         ack_cnt++;
         if (ack_cnt == ((int'(o_fetch_line) == SLOW_LINE) ? SLOW_DELAY : ACK_DELAY))
            fetch_ack = 1'b1;
      end
   end

   function automatic logic [46:0] out_vec();
      return {o_hsd, o_vsd, o_de, o_r, o_g, o_b, o_rd_bank, o_rd_addr,
              o_fetch_req, o_fetch_line, o_underrun, o_frame_start};
   endfunction

   task automatic step();
      @(negedge clk);
      cyc++;
   endtask

   task automatic run_to(input int target);
      while (cyc < target) step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (out_vec() !== RST_EXP) begin
         failures++;
         $display("FAIL reset_values: got %h expected %h", out_vec(), RST_EXP);
      end
      rst = 1'b0;
      cyc = 0;
   endtask

   task automatic test_frame();
      int de_cnt = 0, first_de = -1, hs_line0 = 0, hs_total = 0, vs_total = 0;
      int fs_cnt = 0, fs_pos = -1, req_cnt = 0, req_err = 0, ur_seen = 0, prev_line = -1;
      logic prev_req = 1'b0;
      for (int k = 0; k < FRAME + 2; k++) begin
         int s2;
         int s1;
         step();
         s2 = cyc - 2;
         s1 = cyc - 1;
         if (s2 >= 0 && s2 < FRAME) begin
            if (o_de) begin
               de_cnt++;
               if (first_de < 0) first_de = s2;
            end
            if (!o_hsd) begin
               hs_total++;
               if (s2 < H) hs_line0++;
            end
            if (!o_vsd) vs_total++;
            for (int i = 0; i < 8; i++) begin
               if (s2 == 23 * H + PX_X[i]) begin
                  checks++;
                  if ({o_r, o_g, o_b} !== PX_EXP[i]) begin
                     failures++;
                     $display("FAIL pixel_x%0d: got %h expected %h", PX_X[i], {o_r, o_g, o_b}, PX_EXP[i]);
                  end
               end
            end
            for (int i = 0; i < 7; i++) begin
               if (s2 == DE_L[i] * H + DE_X[i]) begin
                  checks++;
                  if (o_de !== DE_EXP[i]) begin
                     failures++;
                     $display("FAIL de_l%0d_x%0d: got %b expected %b", DE_L[i], DE_X[i], o_de, DE_EXP[i]);
                  end
               end
            end
         end
         if (s1 == 25 * H + 200 || s1 == 27 * H + 705) begin
            logic [8:0] exp_rd;
            exp_rd = (s1 == 25 * H + 200) ? {1'b1, 8'd3} : {1'b0, 8'd255};
            checks++;
            if ({o_rd_bank, o_rd_addr} !== exp_rd) begin
               failures++;
               $display("FAIL rd_bank_addr: got %h expected %h", {o_rd_bank, o_rd_addr}, exp_rd);
            end
         end
         if (o_frame_start) begin
            fs_cnt++;
            fs_pos = cyc;
         end
         if (o_fetch_req && (!prev_req || int'(o_fetch_line) != prev_line)) begin
            if (int'(o_fetch_line) != req_cnt || cyc != (21 + 2 * req_cnt) * H) req_err++;
            req_cnt++;
         end
         prev_req  = o_fetch_req;
         prev_line = int'(o_fetch_line);
         if (o_underrun) ur_seen++;
         if (cyc == 43 * H - 1) begin
            checks++;
            if (!(o_fetch_req === 1'b1 && o_fetch_line === 8'd10)) begin
               failures++;
               $display("FAIL pre_deadline: got req=%b line=%0d expected req=1 line=10", o_fetch_req, o_fetch_line);
            end
         end
         if (cyc == 43 * H) begin
            checks++;
            if (!(o_fetch_req === 1'b1 && o_fetch_line === 8'd11 && o_underrun === 1'b0)) begin
               failures++;
               $display("FAIL ack_at_deadline: got req=%b line=%0d ur=%b expected req=1 line=11 ur=0",
                        o_fetch_req, o_fetch_line, o_underrun);
            end
         end
      end
      checks++;
      if (de_cnt != 384000) begin failures++; $display("FAIL de_count: got %0d expected 384000", de_cnt); end
      checks++;
      if (first_de != 23 * H + 50) begin failures++; $display("FAIL first_de: got %0d expected %0d", first_de, 23 * H + 50); end
      checks++;
      if (hs_line0 != 30) begin failures++; $display("FAIL hsd_line0: got %0d expected 30", hs_line0); end
      checks++;
      if (hs_total != 30 * V) begin failures++; $display("FAIL hsd_total: got %0d expected %0d", hs_total, 30 * V); end
      checks++;
      if (vs_total != 13 * H) begin failures++; $display("FAIL vsd_total: got %0d expected %0d", vs_total, 13 * H); end
      checks++;
      if (fs_cnt != 1 || fs_pos != FRAME) begin
         failures++;
         $display("FAIL frame_start: got count=%0d at=%0d expected count=1 at=%0d", fs_cnt, fs_pos, FRAME);
      end
      checks++;
      if (req_cnt != 240) begin failures++; $display("FAIL req_count: got %0d expected 240", req_cnt); end
      checks++;
      if (req_err != 0) begin failures++; $display("FAIL req_order: got %0d bad requests expected 0", req_err); end
      checks++;
      if (ur_seen != 0) begin failures++; $display("FAIL underrun_frame1: got %0d cycles high expected 0", ur_seen); end
   endtask

   task automatic test_underrun();
      run_to(FRAME + 30 * H);
      skip_line = 5;
      run_to(FRAME + 33 * H - 1);
      checks++;
      if (!(o_fetch_req === 1'b1 && o_fetch_line === 8'd5 && o_underrun === 1'b0)) begin
         failures++;
         $display("FAIL underrun_before: got req=%b line=%0d ur=%b expected req=1 line=5 ur=0",
                  o_fetch_req, o_fetch_line, o_underrun);
      end
      step();
      checks++;
      if (!(o_fetch_req === 1'b1 && o_fetch_line === 8'd6 && o_underrun === 1'b1)) begin
         failures++;
         $display("FAIL underrun_at_deadline: got req=%b line=%0d ur=%b expected req=1 line=6 ur=1",
                  o_fetch_req, o_fetch_line, o_underrun);
      end
      skip_line = -1;
   endtask

   task automatic test_ignore_ack();
      run_to(FRAME + 36 * H);
      extra_ack = 1'b1;
      run_to(FRAME + 36 * H + 500);
      checks++;
      if (o_fetch_req !== 1'b0) begin
         failures++;
         $display("FAIL idle_ack_req: got %b expected 0", o_fetch_req);
      end
      run_to(FRAME + 37 * H - 10);
      extra_ack = 1'b0;
      run_to(FRAME + 37 * H);
      checks++;
      if (!(o_fetch_req === 1'b1 && o_fetch_line === 8'd8)) begin
         failures++;
         $display("FAIL req_after_idle_ack: got req=%b line=%0d expected req=1 line=8", o_fetch_req, o_fetch_line);
      end
      run_to(FRAME + 37 * H + ACK_DELAY - 1);
      checks++;
      if (o_fetch_req !== 1'b1) begin
         failures++;
         $display("FAIL req_hold_until_ack: got %b expected 1", o_fetch_req);
      end
      step();
      checks++;
      if (!(o_fetch_req === 1'b0 && o_fetch_line === 8'd8)) begin
         failures++;
         $display("FAIL req_drop_after_ack: got req=%b line=%0d expected req=0 line=8", o_fetch_req, o_fetch_line);
      end
   endtask

   task automatic test_reset_midframe();
      int early = 0;
      skip_line = 139;
      run_to(FRAME + 300 * H + 500);
      checks++;
      if (!(o_fetch_req === 1'b1 && o_fetch_line === 8'd139 && o_underrun === 1'b1)) begin
         failures++;
         $display("FAIL pending_before_reset: got req=%b line=%0d ur=%b expected req=1 line=139 ur=1",
                  o_fetch_req, o_fetch_line, o_underrun);
      end
      rst = 1'b1;
      step();
      step();
      checks++;
      if (out_vec() !== RST_EXP) begin
         failures++;
         $display("FAIL midframe_reset_values: got %h expected %h", out_vec(), RST_EXP);
      end
      rst = 1'b0;
      skip_line = -1;
      cyc = 0;
      while (cyc < 21 * H) begin
         if (o_fetch_req || o_underrun) early++;
         step();
      end
      checks++;
      if (early != 0) begin
         failures++;
         $display("FAIL quiet_after_reset: got %0d active cycles expected 0", early);
      end
      checks++;
      if (!(o_fetch_req === 1'b1 && o_fetch_line === 8'd0 && o_underrun === 1'b0)) begin
         failures++;
         $display("FAIL first_req_after_reset: got req=%b line=%0d ur=%b expected req=1 line=0 ur=0",
                  o_fetch_req, o_fetch_line, o_underrun);
      end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_underrun();
      test_ignore_ack();
      test_reset_midframe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mtl_scan_gen.md
MTL_SCAN_GEN -- requirements
Module: mtl_scan_gen

Interface
REQ-001 SHALL have parameter H_TOTAL, default 1056, LCD clocks per line.
REQ-002 SHALL have parameter V_TOTAL, default 525, lines per frame.
REQ-003 SHALL have port i_clk  input  1  LCD pixel clock; all logic on rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port o_hsd  output  1  MTL horizontal sync, active-low.
REQ-006 SHALL have port o_vsd  output  1  MTL vertical sync, active-low.
REQ-007 SHALL have port o_de  output  1  high during the 800x480 visible window.
REQ-008 SHALL have port o_r/o_g/o_b  output  8 each  pixel colour.
REQ-009 SHALL have port o_rd_bank  output  1  line-buffer bank to read.
REQ-010 SHALL have port o_rd_addr  output  8  NES pixel x to read.
REQ-011 SHALL have port i_rd_rgb  input  24  {R,G,B} from the line buffer, valid 1 cycle after o_rd_addr.
REQ-012 SHALL have port o_fetch_req  output  1  request for the renderer to fill one NES line.
REQ-013 SHALL have port o_fetch_line  output  8  NES line 0..239 requested.
REQ-014 SHALL have port i_fetch_ack  input  1  one-cycle pulse: requested line is written.
REQ-015 SHALL have port o_underrun  output  1  sticky flag: a line was displayed before its ack.
REQ-016 SHALL have port o_frame_start  output  1  one-cycle pulse at xcnt=0, line=0.

Function
REQ-017 SHALL count xcnt 0..H_TOTAL-1; wrap to 0 and increment line; line wraps 0..V_TOTAL-1.
REQ-018 SHALL drive stage-0 o_hsd low when xcnt<30 and stage-0 o_vsd low when line<13.
REQ-019 SHALL define visible as xcnt 50..849 and line 23..502; de is high exactly there.
REQ-020 SHALL define the image as xcnt 194..705 within visible lines; visible pixels outside it are black (0x000000).
REQ-021 SHALL compute NES x=(xcnt-194)>>1, NES y=(line-23)>>1, and bank=NES y[0]; at stage 1, o_rd_addr and o_rd_bank are registered from these.
REQ-022 SHALL present o_hsd, o_vsd, o_de and rgb 2 cycles after the counter state (stage 2), all aligned; rgb is i_rd_rgb inside the image and 0 elsewhere.
REQ-023 SHALL assert o_fetch_req, with o_fetch_line=n, at xcnt=0 of line 21+2n for n=0..239; the fetch fills bank n[0].
REQ-024 SHALL hold o_fetch_req and o_fetch_line stable until i_fetch_ack; o_fetch_req drops the cycle after the ack.
REQ-025 SHALL ignore i_fetch_ack while o_fetch_req is low.
REQ-026 SHALL, if no ack arrives by xcnt=0 of line 23+2n, drop o_fetch_req, set o_underrun, and keep scanning.
REQ-027 SHALL, when a new request is due while the previous one is pending, apply REQ-026 first and then issue the new request the same cycle.
REQ-028 SHALL, when ack and the underrun deadline coincide, count it as acked with no underrun.
REQ-029 SHALL pulse o_frame_start for one cycle at stage 0, in the cycle where xcnt=0 and line=0.

Reset
REQ-030 SHALL on i_rst: xcnt=0, line=0, pipeline cleared, o_hsd=1, o_vsd=1, o_de=0, rgb=0, o_rd_addr=0, o_rd_bank=0, o_fetch_req=0, o_fetch_line=0, o_underrun=0, o_frame_start=0.
REQ-031 SHALL, on reset asserted mid-frame, abandon any pending fetch without raising underrun and restart at line 0.
REQ-032 SHALL clear o_underrun only by reset.

Structure
REQ-033 SHALL put timing constants in shared package nes_video_pkg: HSYNC_W=30, VSYNC_W=13, H_VIS0=50, V_VIS0=23, IMG_X0=194, IMG_W=512, NES_LINES=240.
REQ-034 SHALL contain one sub-module, mtl_fetch_ctl (the request/ack/underrun FSM, states IDLE, REQ, WAIT_DEADLINE); the counters and video pipeline stay in the top.

Verification
REQ-035 SHALL verify: release reset, run 1 frame -> o_frame_start period is 554400 clocks; o_hsd low 30 clocks per line; o_vsd low 13 lines.
REQ-036 SHALL verify: count o_de per frame -> exactly 384000 high cycles, first at stage-2 of (x=50, line=23).
REQ-037 SHALL verify: i_rd_rgb model returns {addr, addr, addr} -> at line 23, pixel x=194,195 shows 0x000000 and x=196,197 shows 0x010101; x=193 and x=706 show black.
REQ-038 SHALL verify: ack every request 100 clocks late -> 240 requests per frame, lines 0..239 in order, o_underrun stays 0.
REQ-039 SHALL verify: withhold ack for line 5 -> o_fetch_req drops at line 33, xcnt=0; o_underrun=1 and the request for line 6 is issued at line 33.
REQ-040 SHALL verify: reset at line 300 with a request pending -> all outputs at reset values and o_underrun=0; next o_fetch_req for line 0 arrives at line 21.
